// File: rtl/sr_pipe_ctrl.sv
// sr_pipe_ctrl: pipeline sequencer for the schoolRISCV pipelined core.
// Owns the fetch PC and generates the stall and flush controls.
// Branches are serialised: fetch is held until execute resolves the branch.
// Also produces the rs1/rs2 operand forwarding selects.
// Optional perf counters are enabled with the SR_PIPE_PERF_EN macro.
// Without the macro, stall_cnt and flush_cnt are tied to zero.
module sr_pipe_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BOOT_CYCLES = 2,
  parameter int          BR_TIMEOUT  = 7,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_d,
  input  logic             branch_v_e,
  input  logic             branch_tkn_e,
  input  logic [31:0]      pcBranch_e,
  input  logic             halt_req,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_e,
  input  logic             regWrite_e,
  input  logic [4:0]       rd_w,
  input  logic             regWrite_w,
  output logic [31:0]      pc,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             halted,
  output logic             br_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [2:0] {
    S_BOOT     = 3'd0,
    S_RUN      = 3'd1,
    S_BR_WAIT  = 3'd2,
    S_REDIRECT = 3'd3,
    S_HALT     = 3'd4
  } state_t;

  // Counters compare against the last cycle index, so BOOT lasts BOOT_CYCLES cycles
  // and BR_WAIT lasts at most BR_TIMEOUT cycles.
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [3:0] TO_LAST   = 4'(BR_TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  boot_cnt;
  logic [3:0]  boot_cnt_nxt;
  logic [3:0]  to_cnt;
  logic [3:0]  to_cnt_nxt;
  logic [31:0] pc_nxt;
  logic        br_err_nxt;

  // Forwarding select for one source: execute beats writeback, x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    logic [1:0] sel;
    if (regWrite_e && (rd_e != 5'd0) && (rd_e == rs)) begin
      sel = 2'b01;
    end else if (regWrite_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // State, PC, boot/timeout counters and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_BOOT;
      pc       <= RESET_PC;
      boot_cnt <= 4'd0;
      to_cnt   <= 4'd0;
      br_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      boot_cnt <= boot_cnt_nxt;
      to_cnt   <= to_cnt_nxt;
      br_err   <= br_err_nxt;
    end
  end

  // Next-state, next-PC and timeout bookkeeping.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    boot_cnt_nxt = boot_cnt;
    to_cnt_nxt   = to_cnt;
    br_err_nxt   = br_err;
    case (state)
      S_BOOT: begin
        if (boot_cnt == BOOT_LAST) begin
          state_nxt = S_RUN;
        end else begin
          boot_cnt_nxt = boot_cnt + 4'd1;
        end
      end
      S_RUN: begin
        if (branch_d) begin
          state_nxt  = S_BR_WAIT;
          to_cnt_nxt = 4'd0;
        end else if (halt_req) begin
          state_nxt = S_HALT;
        end else begin
          pc_nxt = pc + 32'd4;
        end
      end
      S_BR_WAIT: begin
        if (branch_v_e) begin
          state_nxt = S_REDIRECT;
          if (branch_tkn_e) begin
            pc_nxt = pcBranch_e;
          end else begin
            pc_nxt = pc;
          end
        end else if (to_cnt == TO_LAST) begin
          state_nxt  = S_REDIRECT;
          br_err_nxt = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + 4'd1;
        end
      end
      S_REDIRECT: begin
        // The decode slot is stale here, so branch_d is deliberately ignored.
        state_nxt = S_RUN;
        pc_nxt    = pc + 32'd4;
      end
      S_HALT: begin
        if (!halt_req) begin
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_HALT;
        end
      end
      default: begin
        state_nxt = S_BOOT;
        pc_nxt    = RESET_PC;
      end
    endcase
  end

  // Moore decode of the pipeline controls from the state register only.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    case (state)
      S_BOOT: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
      S_RUN: begin
        stall_f = 1'b0;
      end
      S_BR_WAIT: begin
        stall_f = 1'b1;
        flush_d = 1'b1;
      end
      S_REDIRECT: begin
        flush_d = 1'b1;
      end
      S_HALT: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      default: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
    endcase
  end

  assign halted = (state == S_HALT);

  // Operand forwarding selects for the decode->execute muxes.
  always_comb begin
    fwdA = fwd_sel(rs1_d);
    fwdB = fwd_sel(rs2_d);
  end

`ifdef SR_PIPE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = (state == S_BR_WAIT) || (state == S_HALT);
  assign flush_inc = (state == S_BR_WAIT) && branch_v_e && branch_tkn_e;

  // Saturating perf counters for stall cycles and taken redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
